// File: rtl/gf_seq_pkg.sv
// Shared definitions for the GF(2^m) op sequencer: opcodes, op-word layout,
// FSM states and the opcode-to-interrupt mapping.
package gf_seq_pkg;

   localparam logic [3:0] OpNop  = 4'h0;
   localparam logic [3:0] OpMul  = 4'h1;
   localparam logic [3:0] OpSqr  = 4'h2;
   localparam logic [3:0] OpRed  = 4'h4;
   localparam logic [3:0] OpXor  = 4'h5;
   localparam logic [3:0] OpSwap = 4'h6;
   localparam logic [3:0] OpInv  = 4'h7;
   localparam logic [3:0] OpHalt = 4'hF;

   // Bit positions inside the 5-bit interrupt vector {xor, swap, red, sqr, mul}
   localparam int unsigned IrqMul  = 0;
   localparam int unsigned IrqSqr  = 1;
   localparam int unsigned IrqRed  = 2;
   localparam int unsigned IrqSwap = 3;
   localparam int unsigned IrqXor  = 4;

   // 16-bit op word as stored in the program RAM
   typedef struct packed {
      logic [3:0] opc;
      logic [2:0] start;
      logic [2:0] write;
      logic [1:0] chunks;
      logic       sel_cd;
      logic       sel_ab;
      logic [1:0] rsvd;
   } op_word_t;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StIssue,
      StWait,
      StGap,
      StDone,
      StErr
   } seq_state_e;

   // Opcodes that are handed to the datapath and then waited on
   function automatic logic op_is_issuable(input logic [3:0] opc);
      case (opc)
         OpMul, OpSqr, OpRed, OpXor, OpSwap, OpInv: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   // Which completion interrupt belongs to an opcode; INV runs on the multiplier
   function automatic logic [4:0] irq_mask(input logic [3:0] opc);
      logic [4:0] m;
      m = '0;
      case (opc)
         OpMul, OpInv: m[IrqMul]  = 1'b1;
         OpSqr:        m[IrqSqr]  = 1'b1;
         OpRed:        m[IrqRed]  = 1'b1;
         OpXor:        m[IrqXor]  = 1'b1;
         OpSwap:       m[IrqSwap] = 1'b1;
         default:      m          = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/gf_seq_prog_ram.sv
// Program store: DEPTH x 16 bits, one write port, one registered read port.
// Contents are deliberately not reset so a program survives rst_n.
module gf_seq_prog_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   // Write port and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/gf_op_sequencer.sv
// Command initiator for the GF(2^m) datapath. Steps a host-loaded program of
// op words, drives b_command and the op fields, and waits for the matching
// completion interrupt before moving on.
module gf_op_sequencer
   import gf_seq_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 4096,
   localparam int unsigned PCW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           prog_we,
   input  logic [PCW-1:0] prog_addr,
   input  logic [15:0]    prog_wdata,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           error,
   output logic [PCW-1:0] err_pc,
   output logic [3:0]     b_command,
   output logic [2:0]     start_addr,
   output logic [2:0]     write_addr,
   output logic [1:0]     numbr_of_chunk,
   output logic           select_Ram_C_Or_D,
   output logic           select_Ram_A_Or_B,
   output logic           cmd_inv,
   input  logic           interupt_mul,
   input  logic           interupt_sqr,
   input  logic           interupt_red,
   input  logic           interupt_swap,
   input  logic           interupt_Xor
);

   // Timeout counter keeps at least one bit so TIMEOUT=0 still elaborates
   localparam int unsigned    TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]  TmoLast = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  TmoMax  = '1;
   localparam logic [PCW-1:0] PcLast  = PCW'(DEPTH - 1);

   seq_state_e     state_q, state_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [PCW-1:0] err_pc_q, err_pc_d;
   logic [3:0]     cmd_q, cmd_d;
   logic [2:0]     start_addr_q, start_addr_d;
   logic [2:0]     write_addr_q, write_addr_d;
   logic [1:0]     chunk_q, chunk_d;
   logic           sel_cd_q, sel_cd_d;
   logic           sel_ab_q, sel_ab_d;
   logic           inv_q, inv_d;

   logic           ram_we;
   logic           ram_re;
   logic [15:0]    ram_rdata;
   op_word_t       op;
   logic [4:0]     irq_vec;
   logic [4:0]     mask;
   logic           irq_match;
   logic           irq_other;
   logic           host_owns;
   logic           unused_rsvd;

   // Host may only touch the store while no program is running
   assign host_owns = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
   assign ram_we    = prog_we && host_owns;

   gf_seq_prog_ram #(
      .DEPTH (DEPTH),
      .AW    (PCW)
   ) u_prog_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .re    (ram_re),
      .raddr (pc_q),
      .rdata (ram_rdata)
   );

   assign op          = op_word_t'(ram_rdata);
   assign unused_rsvd = ^op.rsvd;

   // Split interrupts into the one owed by the op in flight and all the others
   always_comb begin
      irq_vec   = '0;
      irq_vec[IrqMul]  = interupt_mul;
      irq_vec[IrqSqr]  = interupt_sqr;
      irq_vec[IrqRed]  = interupt_red;
      irq_vec[IrqSwap] = interupt_swap;
      irq_vec[IrqXor]  = interupt_Xor;
      mask      = irq_mask(cmd_q);
      irq_match = |(irq_vec & mask);
      irq_other = |(irq_vec & ~mask);
   end

   // Next-state logic for the FSM, PC, timeout and output registers
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tmo_d        = tmo_q;
      err_pc_d     = err_pc_q;
      cmd_d        = cmd_q;
      start_addr_d = start_addr_q;
      write_addr_d = write_addr_q;
      chunk_d      = chunk_q;
      sel_cd_d     = sel_cd_q;
      sel_ab_d     = sel_ab_q;
      inv_d        = inv_q;
      ram_re       = 1'b0;

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StFetch;
               pc_d    = '0;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StFetch: begin
            ram_re  = 1'b1;
            state_d = StDecode;
         end
         StDecode: begin
            if (op.opc == OpNop) begin
               pc_d    = pc_q + PCW'(1);
               state_d = (pc_q == PcLast) ? StDone : StFetch;
            end else if (op.opc == OpHalt) begin
               state_d = StDone;
            end else if (op_is_issuable(op.opc)) begin
               state_d      = StIssue;
               cmd_d        = op.opc;
               start_addr_d = op.start;
               write_addr_d = op.write;
               chunk_d      = op.chunks;
               sel_cd_d     = op.sel_cd;
               sel_ab_d     = op.sel_ab;
               inv_d        = (op.opc == OpInv);
            end else begin
               state_d  = StErr;
               err_pc_d = pc_q;
            end
         end
         StIssue: begin
            tmo_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // A stray interrupt wins over a simultaneous matching one
            if (irq_other) begin
               state_d  = StErr;
               err_pc_d = pc_q;
               cmd_d    = '0;
               inv_d    = 1'b0;
            end else if (irq_match) begin
               state_d = StGap;
               cmd_d   = '0;
               inv_d   = 1'b0;
            end else if ((TIMEOUT != 0) && (tmo_q == TmoLast)) begin
               state_d  = StErr;
               err_pc_d = pc_q;
               cmd_d    = '0;
               inv_d    = 1'b0;
            end else if (tmo_q != TmoMax) begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StGap: begin
            pc_d    = pc_q + PCW'(1);
            state_d = (pc_q == PcLast) ? StDone : StFetch;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         tmo_q        <= '0;
         err_pc_q     <= '0;
         cmd_q        <= '0;
         start_addr_q <= '0;
         write_addr_q <= '0;
         chunk_q      <= '0;
         sel_cd_q     <= 1'b0;
         sel_ab_q     <= 1'b0;
         inv_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         tmo_q        <= tmo_d;
         err_pc_q     <= err_pc_d;
         cmd_q        <= cmd_d;
         start_addr_q <= start_addr_d;
         write_addr_q <= write_addr_d;
         chunk_q      <= chunk_d;
         sel_cd_q     <= sel_cd_d;
         sel_ab_q     <= sel_ab_d;
         inv_q        <= inv_d;
      end
   end

   assign busy              = !host_owns;
   assign done              = (state_q == StDone);
   assign error             = (state_q == StErr);
   assign err_pc            = err_pc_q;
   assign b_command         = cmd_q;
   assign start_addr        = start_addr_q;
   assign write_addr        = write_addr_q;
   assign numbr_of_chunk    = chunk_q;
   assign select_Ram_C_Or_D = sel_cd_q;
   assign select_Ram_A_Or_B = sel_ab_q;
   assign cmd_inv           = inv_q;

endmodule

// File: tb/tb_gf_op_sequencer.sv
// Directed bench for gf_op_sequencer (DEPTH=16, TIMEOUT=8).
// Cycle 0 is the cycle in which start is driven; outputs are sampled 1 ns after each edge.
module tb_gf_op_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [15:0] prog_wdata;
   logic       start;
   logic       busy, done, error;
   logic [3:0] err_pc;
   logic [3:0] b_command;
   logic [2:0] start_addr, write_addr;
   logic [1:0] numbr_of_chunk;
   logic       select_Ram_C_Or_D, select_Ram_A_Or_B, cmd_inv;
   logic       interupt_mul, interupt_sqr, interupt_red, interupt_swap, interupt_Xor;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gf_op_sequencer #(
      .DEPTH   (16),
      .TIMEOUT (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .prog_we           (prog_we),
      .prog_addr         (prog_addr),
      .prog_wdata        (prog_wdata),
      .start             (start),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .err_pc            (err_pc),
      .b_command         (b_command),
      .start_addr        (start_addr),
      .write_addr        (write_addr),
      .numbr_of_chunk    (numbr_of_chunk),
      .select_Ram_C_Or_D (select_Ram_C_Or_D),
      .select_Ram_A_Or_B (select_Ram_A_Or_B),
      .cmd_inv           (cmd_inv),
      .interupt_mul      (interupt_mul),
      .interupt_sqr      (interupt_sqr),
      .interupt_red      (interupt_red),
      .interupt_swap     (interupt_swap),
      .interupt_Xor      (interupt_Xor)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_word(input logic [3:0] a, input logic [15:0] d);
      prog_we    = 1'b1;
      prog_addr  = a;
      prog_wdata = d;
      step();
      prog_we    = 1'b0;
   endtask

   // Leaves the bench in cycle 1 (first FETCH cycle)
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(3);
      checks++;
      if ({busy, done, error} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got %b want 000", {busy, done, error});
      end
      checks++;
      if ({b_command, start_addr, write_addr, numbr_of_chunk, cmd_inv, err_pc} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0",
                  {b_command, start_addr, write_addr, numbr_of_chunk, cmd_inv, err_pc});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_mul_halt();
      write_word(4'd0, 16'h1200);   // MUL s=1
      write_word(4'd1, 16'hF000);   // HALT
      pulse_start();
      checks++;
      if (busy !== 1'b1 || b_command !== 4'h0) begin
         failures++;
         $display("FAIL mul_cycle1: got busy=%b cmd=%h want busy=1 cmd=0", busy, b_command);
      end
      step(2);
      checks++;
      if (b_command !== 4'h1 || start_addr !== 3'd1) begin
         failures++;
         $display("FAIL mul_issue: got cmd=%h sa=%0d want cmd=1 sa=1", b_command, start_addr);
      end
      // Start and a write that would replace HALT with MUL; both must be ignored
      start      = 1'b1;
      prog_we    = 1'b1;
      prog_addr  = 4'd1;
      prog_wdata = 16'h1200;
      step();
      start   = 1'b0;
      prog_we = 1'b0;
      step(6);
      checks++;
      if (b_command !== 4'h1 || error !== 1'b0) begin
         failures++;
         $display("FAIL mul_hold: got cmd=%h err=%b want cmd=1 err=0", b_command, error);
      end
      interupt_mul = 1'b1;
      step();
      interupt_mul = 1'b0;
      checks++;
      if (b_command !== 4'h0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mul_gap: got cmd=%h busy=%b want cmd=0 busy=1", b_command, busy);
      end
      step(2);
      checks++;
      if (done !== 1'b0 || b_command !== 4'h0) begin
         failures++;
         $display("FAIL mul_early_done: got done=%b cmd=%h want done=0 cmd=0", done, b_command);
      end
      step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mul_done: got done=%b busy=%b want done=1 busy=0", done, busy);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL mul_done_pulse: got done=%b want 0", done);
      end
   endtask

   task automatic test_swap();
      write_word(4'd0, 16'h6578);   // SWAP s=2 w=5 ch=3 CD=1 AB=0
      write_word(4'd1, 16'hF000);
      pulse_start();
      step(2);
      checks++;
      if ({b_command, start_addr, write_addr, numbr_of_chunk, select_Ram_C_Or_D,
           select_Ram_A_Or_B} !== {4'h6, 3'd2, 3'd5, 2'd3, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL swap_issue: got cmd=%h sa=%0d wa=%0d ch=%0d cd=%b ab=%b want 6 2 5 3 1 0",
                  b_command, start_addr, write_addr, numbr_of_chunk, select_Ram_C_Or_D,
                  select_Ram_A_Or_B);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({b_command, write_addr, numbr_of_chunk, select_Ram_C_Or_D, select_Ram_A_Or_B}
             !== {4'h6, 3'd5, 2'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL swap_hold%0d: got cmd=%h wa=%0d ch=%0d cd=%b ab=%b want 6 5 3 1 0",
                     i, b_command, write_addr, numbr_of_chunk, select_Ram_C_Or_D,
                     select_Ram_A_Or_B);
         end
      end
      interupt_swap = 1'b1;
      step();
      interupt_swap = 1'b0;
      checks++;
      if (b_command !== 4'h0) begin
         failures++;
         $display("FAIL swap_gap: got cmd=%h want 0", b_command);
      end
      step(3);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL swap_done: got done=%b want 1", done);
      end
   endtask

   task automatic test_wrong_irq();
      write_word(4'd0, 16'h2600);   // SQR s=3
      write_word(4'd1, 16'hF000);
      pulse_start();
      step(2);
      checks++;
      if (b_command !== 4'h2 || start_addr !== 3'd3) begin
         failures++;
         $display("FAIL sqr_issue: got cmd=%h sa=%0d want cmd=2 sa=3", b_command, start_addr);
      end
      step();
      interupt_red = 1'b1;
      step();
      interupt_red = 1'b0;
      checks++;
      if ({error, busy, b_command, err_pc} !== {1'b1, 1'b0, 4'h0, 4'd0}) begin
         failures++;
         $display("FAIL wrongirq_err: got err=%b busy=%b cmd=%h pc=%0d want 1 0 0 0",
                  error, busy, b_command, err_pc);
      end
      step(2);
      checks++;
      if (error !== 1'b1) begin
         failures++;
         $display("FAIL wrongirq_sticky: got err=%b want 1", error);
      end
      pulse_start();
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wrongirq_restart: got err=%b busy=%b want err=0 busy=1", error, busy);
      end
      // Matching and stray interrupt together still faults
      step(3);
      interupt_sqr  = 1'b1;
      interupt_swap = 1'b1;
      step();
      interupt_sqr  = 1'b0;
      interupt_swap = 1'b0;
      checks++;
      if (error !== 1'b1 || b_command !== 4'h0) begin
         failures++;
         $display("FAIL bothirq_err: got err=%b cmd=%h want err=1 cmd=0", error, b_command);
      end
      pulse_start();
      step(3);
      interupt_sqr = 1'b1;
      step();
      interupt_sqr = 1'b0;
      checks++;
      if (error !== 1'b0 || b_command !== 4'h0) begin
         failures++;
         $display("FAIL sqr_gap: got err=%b cmd=%h want err=0 cmd=0", error, b_command);
      end
      step(3);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL sqr_done: got done=%b want 1", done);
      end
   endtask

   task automatic test_timeout();
      write_word(4'd0, 16'h0000);   // NOP
      write_word(4'd1, 16'h4C00);   // RED s=6
      write_word(4'd2, 16'hF000);
      pulse_start();
      step(4);
      checks++;
      if (b_command !== 4'h4 || start_addr !== 3'd6) begin
         failures++;
         $display("FAIL tmo_issue: got cmd=%h sa=%0d want cmd=4 sa=6", b_command, start_addr);
      end
      step(8);
      checks++;
      if (error !== 1'b0 || b_command !== 4'h4) begin
         failures++;
         $display("FAIL tmo_early: got err=%b cmd=%h want err=0 cmd=4", error, b_command);
      end
      step();
      checks++;
      if ({error, busy, b_command, err_pc} !== {1'b1, 1'b0, 4'h0, 4'd1}) begin
         failures++;
         $display("FAIL tmo_err: got err=%b busy=%b cmd=%h pc=%0d want 1 0 0 1",
                  error, busy, b_command, err_pc);
      end
      // Illegal opcode 3 faults straight from decode
      write_word(4'd0, 16'h3000);
      pulse_start();
      step(2);
      checks++;
      if ({error, b_command, err_pc} !== {1'b1, 4'h0, 4'd0}) begin
         failures++;
         $display("FAIL illegal_err: got err=%b cmd=%h pc=%0d want 1 0 0", error, b_command, err_pc);
      end
   endtask

   task automatic test_full_program();
      logic [3:0] ops [6];
      logic [3:0] opc;
      bit seen;
      ops[0] = 4'h1; ops[1] = 4'h2; ops[2] = 4'h4;
      ops[3] = 4'h5; ops[4] = 4'h6; ops[5] = 4'h7;
      for (int i = 0; i < 16; i++) begin
         write_word(4'(i), {ops[i % 6], 3'(i), 9'b0});
      end
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         opc  = ops[i % 6];
         seen = 1'b0;
         for (int c = 0; c < 8; c++) begin
            if (b_command !== 4'h0) begin
               seen = 1'b1;
               break;
            end
            step();
         end
         checks++;
         if (!seen) begin
            failures++;
            $display("FAIL prog_word%0d_timeout: got no command want %h", i, opc);
            return;
         end
         checks++;
         if ({b_command, start_addr, cmd_inv} !== {opc, 3'(i), (opc == 4'h7)}) begin
            failures++;
            $display("FAIL prog_word%0d: got cmd=%h sa=%0d inv=%b want %h %0d %b",
                     i, b_command, start_addr, cmd_inv, opc, i % 8, (opc == 4'h7));
         end
         step();
         case (opc)
            4'h1, 4'h7: interupt_mul  = 1'b1;
            4'h2:       interupt_sqr  = 1'b1;
            4'h4:       interupt_red  = 1'b1;
            4'h5:       interupt_Xor  = 1'b1;
            default:    interupt_swap = 1'b1;
         endcase
         step();
         {interupt_mul, interupt_sqr, interupt_red, interupt_swap, interupt_Xor} = '0;
         checks++;
         if ({b_command, cmd_inv, error} !== 6'b0) begin
            failures++;
            $display("FAIL prog_gap%0d: got cmd=%h inv=%b err=%b want 0 0 0",
                     i, b_command, cmd_inv, error);
         end
      end
      step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL prog_wrap_done: got done=%b busy=%b want done=1 busy=0", done, busy);
      end
      step();
   endtask

   task automatic test_reset_mid_op();
      write_word(4'd0, 16'h5800);   // XOR s=4
      write_word(4'd1, 16'hF000);
      pulse_start();
      step(2);
      checks++;
      if (b_command !== 4'h5 || start_addr !== 3'd4) begin
         failures++;
         $display("FAIL xor_issue: got cmd=%h sa=%0d want cmd=5 sa=4", b_command, start_addr);
      end
      step(2);
      rst_n = 1'b0;
      step();
      checks++;
      if ({b_command, start_addr, busy, done, error} !== 10'h0) begin
         failures++;
         $display("FAIL midreset_outputs: got cmd=%h sa=%0d busy=%b done=%b err=%b want all 0",
                  b_command, start_addr, busy, done, error);
      end
      rst_n = 1'b1;
      step();
      pulse_start();
      step(2);
      checks++;
      if (b_command !== 4'h5 || start_addr !== 3'd4) begin
         failures++;
         $display("FAIL midreset_rerun: got cmd=%h sa=%0d want cmd=5 sa=4", b_command, start_addr);
      end
      step();
      interupt_Xor = 1'b1;
      step();
      interupt_Xor = 1'b0;
      step(3);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL midreset_done: got done=%b want 1", done);
      end
   endtask

   task automatic test_back_to_back();
      // Write INV s=7 to word 0 in the same cycle as start
      prog_we    = 1'b1;
      prog_addr  = 4'd0;
      prog_wdata = 16'h7E00;
      start      = 1'b1;
      step();
      prog_we = 1'b0;
      start   = 1'b0;
      step(2);
      checks++;
      if ({b_command, start_addr, cmd_inv} !== {4'h7, 3'd7, 1'b1}) begin
         failures++;
         $display("FAIL b2b_issue: got cmd=%h sa=%0d inv=%b want 7 7 1",
                  b_command, start_addr, cmd_inv);
      end
      step();
      interupt_mul = 1'b1;
      step();
      interupt_mul = 1'b0;
      checks++;
      if (cmd_inv !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL b2b_gap: got inv=%b err=%b want inv=0 err=0", cmd_inv, error);
      end
      step(3);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL b2b_done: got done=%b want 1", done);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      prog_we    = 1'b0;
      prog_addr  = '0;
      prog_wdata = '0;
      start      = 1'b0;
      {interupt_mul, interupt_sqr, interupt_red, interupt_swap, interupt_Xor} = '0;
      test_reset();
      test_mul_halt();
      test_swap();
      test_wrong_irq();
      test_timeout();
      test_full_program();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
